// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writeback, the load-return
// unit (A) and the debug host (B), with starvation protection and registered write outputs.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  cnt_a_r;
  logic [3:0]  cnt_b_r;
  logic        rr_r;
  logic        starve_a_s;
  logic        starve_b_s;
  logic        grant_wb_s;
  logic        grant_a_s;
  logic        grant_b_s;
  logic [4:0]  gnt_addr_s;
  logic [31:0] gnt_data_s;

  // A saturated counter only matters while its requester is still presenting a write
  assign starve_a_s = a_valid && (cnt_a_r == LIMIT);
  assign starve_b_s = b_valid && (cnt_b_r == LIMIT);

  // Priority grant: starving secondary, then writeback, then round-robin secondaries
  always_comb begin
    grant_wb_s = 1'b0;
    grant_a_s  = 1'b0;
    grant_b_s  = 1'b0;
    if (starve_a_s && starve_b_s) begin
      if (rr_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (starve_a_s) begin
      grant_a_s = 1'b1;
    end else if (starve_b_s) begin
      grant_b_s = 1'b1;
    end else if (wb_valid) begin
      grant_wb_s = 1'b1;
    end else if (a_valid && b_valid) begin
      if (rr_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else if (b_valid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_wb_s = 1'b0;
    end
  end

  // Write payload select; kept apart from the handshake outputs
  always_comb begin
    gnt_addr_s = wb_addr;
    gnt_data_s = wb_data;
    case ({grant_a_s, grant_b_s})
      2'b10: begin
        gnt_addr_s = a_addr;
        gnt_data_s = a_data;
      end
      2'b01: begin
        gnt_addr_s = b_addr;
        gnt_data_s = b_data;
      end
      default: begin
        gnt_addr_s = wb_addr;
        gnt_data_s = wb_data;
      end
    endcase
  end

  assign a_ready  = !rst && grant_a_s;
  assign b_ready  = !rst && grant_b_s;
  assign wb_stall = !rst && wb_valid && (grant_a_s || grant_b_s);

  // Arbitration state and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_r  <= 4'd0;
      cnt_b_r  <= 4'd0;
      rr_r     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      if (!a_valid || grant_a_s) begin
        cnt_a_r <= 4'd0;
      end else if (cnt_a_r != LIMIT) begin
        cnt_a_r <= cnt_a_r + 4'd1;
      end
      if (!b_valid || grant_b_s) begin
        cnt_b_r <= 4'd0;
      end else if (cnt_b_r != LIMIT) begin
        cnt_b_r <= cnt_b_r + 4'd1;
      end
      if (grant_a_s) begin
        rr_r <= 1'b1;
      end else if (grant_b_s) begin
        rr_r <= 1'b0;
      end
      if (grant_wb_s || grant_a_s || grant_b_s) begin
        rf_we    <= (gnt_addr_s != 5'd0);
        rf_waddr <= gnt_addr_s;
        rf_wdata <= gnt_data_s;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file among three writers: the pipeline writeback stage, the load-return unit (requester A), and the debug host (requester B). Writeback has priority but can be stalled. A saturating starvation counter guarantees forward progress for A and B, and A/B alternate round-robin when both wait. The granted write is registered and driven onto the register file's we/writeaddr/writedata one cycle after acceptance.

## Interface
- STARVE_LIMIT, 4: consecutive waiting cycles after which a secondary requester preempts writeback; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  writeback write request
- wb_addr  in  5  writeback destination register
- wb_data  in  32  writeback data
- wb_stall  out  1  writeback not accepted this cycle; pipeline holds wb_* stable
- a_valid  in  1  requester A write request
- a_addr  in  5  requester A destination
- a_data  in  32  requester A data
- a_ready  out  1  requester A accepted this cycle
- b_valid  in  1  requester B write request
- b_addr  in  5  requester B destination
- b_data  in  32  requester B data
- b_ready  out  1  requester B accepted this cycle
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)

## Operation
- At most one grant per cycle. A handshake completes when valid & ready, or for writeback when wb_valid & !wb_stall.
- Per-secondary counter cntA/cntB, 4 bits:
  - Cleared when the requester is granted or its valid is low.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - starveX = (cntX == STARVE_LIMIT).
- Grant priority, evaluated combinationally each cycle:
  1. If starveA or starveB, grant the starving secondary. If both are starving, grant the one selected by rr.
  2. Else if wb_valid, grant writeback.
  3. Else if a_valid and b_valid, grant the one selected by rr.
  4. Else grant whichever secondary is valid.
  5. Else no grant.
- rr is a 1-bit pointer: 0 selects A, 1 selects B. After any A grant rr becomes 1; after any B grant rr becomes 0. A writeback grant leaves rr unchanged.
- wb_stall = wb_valid & (a secondary was granted this cycle).
- a_ready and b_ready are high only in the granted cycle. Requesters must not drop valid or change addr/data while valid is high and ready is low.
- Output register, on a grant:
  - rf_waddr and rf_wdata load the granted address and data.
  - rf_we loads (granted addr != 0).
  - With no grant: rf_we loads 0, and rf_waddr/rf_wdata hold their values.
- Writes to address 0 complete the handshake normally but never assert rf_we.
- Writes to address 29 are passed through unchanged. The register file ignores them on read.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rr=0, cntA=cntB=0.
- While rst is high, a_ready, b_ready and wb_stall are forced to 0.
- Reset is asynchronous. Asserting it mid-write clears rf_we immediately, before the next edge. Any handshake in that cycle is discarded, and requesters must re-present.
- Latency: a request accepted in cycle N appears on rf_* in cycle N+1. It is readable through the register file bypass in N+1 and from storage in N+2.
- ready and wb_stall are combinational from the valids and the registered state. There are no combinational paths from addr or data.
- Starvation bound: a continuously valid secondary is granted no later than STARVE_LIMIT cycles after first assertion. If the other secondary is also starving, the bound is STARVE_LIMIT+1.
- Writeback throughput is 1 write per cycle when both secondaries are idle.

## Test plan
- Writeback only: wb_valid=1, addr=5, data=0xDEADBEEF in cycle 0. Expect wb_stall=0, and in cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. With wb_valid=0 in cycle 1, rf_we=0 in cycle 2.
- Round-robin: from reset, wb idle, a_valid=b_valid=1 held for 4 cycles. Expect grants A,B,A,B, and rf_wdata alternates a_data, b_data starting in cycle 1.
- Starvation (STARVE_LIMIT=4): wb_valid=1 every cycle, a_valid=1 from cycle 0. Expect a_ready=0 in cycles 0-3, and a_ready=1 with wb_stall=1 in cycle 4. rf_waddr=a_addr in cycle 5; writeback is granted again in cycle 5 and written in cycle 6.
- Both starving: wb_valid=1 continuously, a_valid=b_valid=1 from cycle 0 with rr=0. Expect A granted in cycle 4 and B granted in cycle 5. The writeback stall lasts exactly those 2 cycles.
- Register 0: b_valid=1, b_addr=0, data=0x12345678, wb idle. Expect b_ready=1 in cycle 0, rf_we=0 in cycle 1, and rr=0 afterwards.
- Reset mid-operation: rf_we=1 and cntA=3, then rst pulsed asynchronously mid-cycle. Expect rf_we=0 immediately, a_ready=b_ready=wb_stall=0 during reset, and after release cntA restarts from 0 with rr=0.
